riscv_dmem_resp: RTL
====================

Name: riscv_dmem_resp

Overview:
- Data-memory responder for the pipeline core: the target end of the core's data-memory port (address, write enable, write byte-enable code, write data, read data).
- Holds a word-organised RAM and places store bytes into lanes according to endianness.
- Writes commit through a one-entry pending-write register. Reads are combinational, with forwarding from that register.
- After reset, an init FSM zero-clears the array and reports busy so the system can hold the core off until the clear completes.

Parameters:
- MP_DATA_WIDTH, 32, data word width; only 32 is supported.
- MP_ADDR_WIDTH, 10, word-index width; DEPTH = 2**MP_ADDR_WIDTH words.
- MP_ENDIANESS, `RISCV_BIG_ENDIAN, byte-lane order; the alternative is `RISCV_LITTLE_ENDIAN.

Ports:
- iclk  in  1  clock; all state updates on the rising edge.
- irst  in  1  asynchronous, active-high reset.
- iaddr  in  32  byte address from core ALU result.
- iwr_en  in  1  store strobe; one store per cycle max.
- iwr_be  in  2  store size: 00 word, 01 halfword, 10 byte, 11 treated as word.
- iwr_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- ord_data  out  32  full read word at iaddr's word index; the core extracts sub-word loads.
- oinit_busy  out  1  high while the array is being cleared.

Behaviour:

Addressing and lane mapping:
- idx = iaddr[MP_ADDR_WIDTH+1:2]; upper address bits are ignored (aliasing) unless the optional feature is enabled.
- Little-endian lanes: byte offset k -> bits [8k+7:8k].
- Big-endian lanes: byte offset k -> bits [31-8k:24-8k].
- Byte store: mask selects the single lane at iaddr[1:0]; data is replicated to that lane.
- Halfword store: lanes {2*iaddr[1], 2*iaddr[1]+1} in the chosen endianness.
- Halfword store with iaddr[0]=1: dropped, no state change.
- Word store: mask 4'b1111; iaddr[1:0] is ignored.

Write pipeline:
- Cycle N, iwr_en=1 in READY: capture pend_vld=1, pend_idx, pend_mask[3:0], pend_data (lane-aligned).
- Cycle N+1: the array bytes under pend_mask take pend_data.
- If a new store arrives in N+1, it is captured in the same cycle; there is no stall and no loss under back-to-back stores.
- pend_vld clears when there is no new store.

Read path (combinational, zero latency):
- ord_data = array[idx], with each lane i replaced by pend_data lane i when pend_vld && pend_idx==idx && pend_mask[i].
- A store followed by a load to the same word in the next cycle therefore returns the new data.

Init FSM, states CLEAR and READY:
- irst asserted: state=CLEAR, cnt=0, pend_vld=0, oinit_busy=1, ord_data=0.
- CLEAR: each cycle array[cnt]=0, cnt++. The write at cnt==DEPTH-1 transitions to READY; oinit_busy falls at the start of the next cycle, DEPTH cycles after reset release.
- CLEAR: iwr_en is ignored; ord_data is forced to 0.
- Reset asserted mid-CLEAR: restarts at cnt=0.
- Reset asserted in READY: also drops the pending write (not committed).
- READY is terminal until the next reset.

Reset values: oinit_busy=1, ord_data=0, pend_vld=0, cnt=0.

Optional Feature:
- Macro RISCV_DMEM_BOUNDS_CHECK_EN.
- Defined:
  - adds output oaddr_err (1 bit, reset 0);
  - a store whose iaddr[31:MP_ADDR_WIDTH+2] is nonzero, or a misaligned halfword store, is dropped and sets oaddr_err;
  - oaddr_err is sticky until irst.
- Undefined:
  - no oaddr_err port;
  - out-of-range addresses alias onto idx;
  - a misaligned halfword store is silently dropped.

Test Plan:
1. Init clear: release irst -> oinit_busy=1 for exactly 1024 cycles, then 0; a read of any address returns 32'h0 after the clear.
2. Big-endian byte store: iaddr=0x11, iwr_be=10, iwr_data=0xAB -> the read of word 0x10 gives 32'h00AB0000.
   - Same sequence with `RISCV_LITTLE_ENDIAN -> 32'h0000AB00.
3. Forwarding: word store 0x12345678 to 0x40 in cycle N -> the read of 0x40 in cycle N+1 is 0x12345678.
   - A halfword store 0xBEEF to 0x42 (big-endian) in N+1 -> the read of 0x40 in N+2 is 0x1234BEEF.
4. Back-to-back stores to 0x0, 0x4, 0x8 (values 1, 2, 3) on consecutive cycles -> later reads return 1, 2, 3 with no loss.
5. Reset mid-CLEAR at cnt=500 -> the restart takes the full 1024 cycles; a store issued while oinit_busy=1 has no effect.
6. With RISCV_DMEM_BOUNDS_CHECK_EN:
   - store to 0x1000 -> oaddr_err=1 and word 0 is unchanged;
   - halfword store to 0x3 -> oaddr_err stays 1 and memory is unchanged;
   - irst -> oaddr_err=0.

Source files
------------

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder: word RAM with endian-aware byte lanes, one-entry pending write with read forwarding,
// and a post-reset zero-clear FSM. Define RISCV_DMEM_BOUNDS_CHECK_EN to drop bad stores and flag them on oaddr_err.
`ifndef RISCV_BIG_ENDIAN
`define RISCV_BIG_ENDIAN 1'b1
`endif
`ifndef RISCV_LITTLE_ENDIAN
`define RISCV_LITTLE_ENDIAN 1'b0
`endif

module riscv_dmem_resp #(
  parameter int MP_DATA_WIDTH = 32,
  parameter int MP_ADDR_WIDTH = 10,
  parameter bit MP_ENDIANESS  = `RISCV_BIG_ENDIAN
) (
  input  logic                     iclk,
  input  logic                     irst,
  input  logic [31:0]              iaddr,
  input  logic                     iwr_en,
  input  logic [1:0]               iwr_be,
  input  logic [MP_DATA_WIDTH-1:0] iwr_data,
  output logic [MP_DATA_WIDTH-1:0] ord_data,
  output logic                     oinit_busy
`ifdef RISCV_DMEM_BOUNDS_CHECK_EN
  ,
  output logic                     oaddr_err
`endif
);

  localparam int NUM_LANES = MP_DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** MP_ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_e;

  typedef struct packed {
    logic                     vld;
    logic [MP_ADDR_WIDTH-1:0] idx;
    logic [NUM_LANES-1:0]     mask;
    logic [MP_DATA_WIDTH-1:0] data;
  } pend_t;

  state_e                   state_q, state_d;
  logic [MP_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  pend_t                    pend_q, pend_d;

  logic [MP_ADDR_WIDTH-1:0] rd_idx;
  logic [NUM_LANES-1:0]     st_mask;
  logic [MP_DATA_WIDTH-1:0] st_data;
  logic                     st_misal, st_bad, st_ok;
  logic [NUM_LANES-1:0][7:0] rd_lane;

  assign rd_idx = iaddr[MP_ADDR_WIDTH+1:2];

  function automatic logic [1:0] lane_of(input logic [1:0] k);
    return (MP_ENDIANESS == `RISCV_BIG_ENDIAN) ? ~k : k;
  endfunction

  // Store data is replicated across lanes; the mask alone picks the lanes that commit.
  always_comb begin
    st_mask  = '0;
    st_data  = iwr_data;
    st_misal = 1'b0;
    unique case (iwr_be)
      2'b10: begin
        st_mask[lane_of(iaddr[1:0])] = 1'b1;
        st_data = {NUM_LANES{iwr_data[7:0]}};
      end
      2'b01: begin
        st_misal = iaddr[0];
        st_mask[lane_of({iaddr[1], 1'b0})] = 1'b1;
        st_mask[lane_of({iaddr[1], 1'b1})] = 1'b1;
        st_data = {(NUM_LANES/2){iwr_data[15:0]}};
      end
      default: st_mask = '1;
    endcase
  end

`ifdef RISCV_DMEM_BOUNDS_CHECK_EN
  logic err_q, err_d;
  assign st_bad    = st_misal | (|iaddr[31:MP_ADDR_WIDTH+2]);
  assign err_d     = err_q | (iwr_en & (state_q == READY) & st_bad);
  assign oaddr_err = err_q;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
`else
  logic unused_addr_hi;
  assign st_bad         = st_misal;
  assign unused_addr_hi = &{1'b0, iaddr[31:MP_ADDR_WIDTH+2]};
`endif

  assign st_ok = iwr_en & (state_q == READY) & ~st_bad;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_d = READY;
        busy_d  = 1'b0;
      end
    end
  end

  always_comb begin
    pend_d     = pend_q;
    pend_d.vld = st_ok;
    if (st_ok) begin
      pend_d.idx  = rd_idx;
      pend_d.mask = st_mask;
      pend_d.data = st_data;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge iclk) begin
      if (state_q == CLEAR)
        mem[cnt_q] <= 8'h00;
      else if (pend_q.vld && pend_q.mask[i])
        mem[pend_q.idx] <= pend_q.data[8*i +: 8];
    end

    // Uncommitted store bytes win over the array for the same word.
    assign rd_lane[i] = (pend_q.vld && pend_q.idx == rd_idx && pend_q.mask[i]) ?
                        pend_q.data[8*i +: 8] : mem[rd_idx];
  end

  assign ord_data   = busy_q ? '0 : rd_lane;
  assign oinit_busy = busy_q;

endmodule
